// File: rtl/fp_align_stage_pkg.sv
// Shared types and widths for the binary32 alignment pre-stage.
package fp_align_pkg;

   localparam int EXP_W        = 8;
   localparam int FRAC_W       = 23;
   localparam int MANT_W       = 27;
   localparam int STICKY_LIMIT = 27;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp_eff;
      logic [MANT_W-1:0] mant;
   } operand_t;

   // Denormals read as exponent 1 with a clear hidden bit.
   function automatic operand_t unpack(input logic [31:0] v);
      operand_t o;
      o.sign = v[31];
      if (v[30:23] == 8'd0) begin
         o.exp_eff = 8'd1;
         o.mant    = {1'b0, v[22:0], 3'b000};
      end else begin
         o.exp_eff = v[30:23];
         o.mant    = {1'b1, v[22:0], 3'b000};
      end
      return o;
   endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// Operand-in / aligned-pair-out handshake bundle of the alignment stage.
interface fp_align_stage_if;
   import fp_align_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [31:0]       op1;
   logic [31:0]       op2;
   logic              out_valid;
   logic              out_ready;
   logic              sign_big;
   logic              eff_sub;
   logic [EXP_W-1:0]  exp_out;
   logic [MANT_W-1:0] mant_big;
   logic [MANT_W-1:0] mant_small;
   logic              is_inf;
   logic              is_nan;

   modport master (
      output in_valid, op1, op2, out_ready,
      input  in_ready, out_valid, sign_big, eff_sub, exp_out,
             mant_big, mant_small, is_inf, is_nan
   );

   modport slave (
      input  in_valid, op1, op2, out_ready,
      output in_ready, out_valid, sign_big, eff_sub, exp_out,
             mant_big, mant_small, is_inf, is_nan
   );
endinterface

// File: rtl/fp_align_stage_sticky_shifter.sv
// Combinational right shift by k with every shifted-out bit folded into bit0.
module fp_sticky_shifter
   import fp_align_pkg::*;
(
   input  logic [MANT_W-1:0] din,
   input  logic [4:0]        k,
   output logic [MANT_W-1:0] dout
);

   logic [MANT_W-1:0] lost_mask_s;

   // Mask covers the k low bits (old bit0 included) that leave the word.
   always_comb begin
      lost_mask_s = (27'd1 << k) - 27'd1;
      dout        = (din >> k) | {26'd0, |(din & lost_mask_s)};
   end

endmodule

// File: rtl/fp_align_stage.sv
// Binary32 operand unpack/order/align stage feeding the adder core.
// Optional NaN/Inf detection is enabled by defining FP_SPECIAL_DETECT_EN.
module fp_align_stage
   import fp_align_pkg::*;
#(
   parameter int SHIFT_PER_CYCLE = 1
) (
   input logic             clk,
   input logic             rst,
   fp_align_stage_if.slave bus
);

   localparam logic [4:0] STEP = 5'(SHIFT_PER_CYCLE);

   state_t            state_r, state_nxt_s;
   logic [4:0]        remaining_r;
   logic              sign_big_r, eff_sub_r;
   logic [EXP_W-1:0]  exp_r;
   logic [MANT_W-1:0] mant_big_r, mant_small_r;
   operand_t          opa_s, opb_s, big_s, small_s;
   logic [EXP_W-1:0]  d_s;
   logic [4:0]        k_s;
   logic [MANT_W-1:0] shifted_s;
   logic              accept_s, special_s, nan_s;

   // Unpack, order by magnitude (ties keep op1 big) and form the exponent gap.
   always_comb begin
      opa_s = unpack(bus.op1);
      opb_s = unpack(bus.op2);
      if (bus.op1[30:0] >= bus.op2[30:0]) begin
         big_s   = opa_s;
         small_s = opb_s;
      end else begin
         big_s   = opb_s;
         small_s = opa_s;
      end
      d_s = big_s.exp_eff - small_s.exp_eff;
      if (remaining_r < STEP) begin
         k_s = remaining_r;
      end else begin
         k_s = STEP;
      end
   end

`ifdef FP_SPECIAL_DETECT_EN
   logic is_inf_r, is_nan_r;
   logic nan1_s, nan2_s, inf1_s, inf2_s;

   // Classify exponent-255 operands at accept time.
   always_comb begin
      nan1_s    = (bus.op1[30:23] == 8'hFF) && (bus.op1[22:0] != 23'd0);
      nan2_s    = (bus.op2[30:23] == 8'hFF) && (bus.op2[22:0] != 23'd0);
      inf1_s    = (bus.op1[30:23] == 8'hFF) && (bus.op1[22:0] == 23'd0);
      inf2_s    = (bus.op2[30:23] == 8'hFF) && (bus.op2[22:0] == 23'd0);
      special_s = (bus.op1[30:23] == 8'hFF) || (bus.op2[30:23] == 8'hFF);
      nan_s     = nan1_s || nan2_s || (inf1_s && inf2_s && (bus.op1[31] != bus.op2[31]));
   end

   // Flags travel with the data and are rewritten on every accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_inf_r <= 1'b0;
         is_nan_r <= 1'b0;
      end else if (accept_s) begin
         is_nan_r <= special_s && nan_s;
         is_inf_r <= special_s && !nan_s;
      end else begin
         is_inf_r <= is_inf_r;
         is_nan_r <= is_nan_r;
      end
   end

   assign bus.is_inf = is_inf_r;
   assign bus.is_nan = is_nan_r;
`else
   assign special_s  = 1'b0;
   assign nan_s      = 1'b0;
   assign bus.is_inf = 1'b0;
   assign bus.is_nan = 1'b0;
`endif

   fp_sticky_shifter u_shifter (
      .din  (mant_small_r),
      .k    (k_s),
      .dout (shifted_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; gaps of 0 or beyond the sticky limit skip SHIFT.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               accept_s = 1'b1;
               if ((d_s == 8'd0) || (d_s >= 8'(STICKY_LIMIT)) || special_s) begin
                  state_nxt_s = HOLD;
               end else begin
                  state_nxt_s = SHIFT;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (remaining_r <= STEP) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Operand capture on accept, then iterative alignment of the small mantissa.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         remaining_r  <= 5'd0;
         sign_big_r   <= 1'b0;
         eff_sub_r    <= 1'b0;
         exp_r        <= 8'd0;
         mant_big_r   <= 27'd0;
         mant_small_r <= 27'd0;
      end else if (accept_s) begin
         sign_big_r <= big_s.sign;
         eff_sub_r  <= bus.op1[31] ^ bus.op2[31];
         exp_r      <= big_s.exp_eff;
         mant_big_r <= big_s.mant;
         if ((d_s >= 8'(STICKY_LIMIT)) && !special_s) begin
            mant_small_r <= {26'd0, |small_s.mant};
            remaining_r  <= 5'd0;
         end else begin
            mant_small_r <= small_s.mant;
            remaining_r  <= d_s[4:0];
         end
      end else if (state_r == SHIFT) begin
         mant_small_r <= shifted_s;
         remaining_r  <= remaining_r - k_s;
      end else begin
         mant_small_r <= mant_small_r;
         remaining_r  <= remaining_r;
      end
   end

   assign bus.in_ready   = (state_r == IDLE);
   assign bus.out_valid  = (state_r == HOLD);
   assign bus.sign_big   = sign_big_r;
   assign bus.eff_sub    = eff_sub_r;
   assign bus.exp_out    = exp_r;
   assign bus.mant_big   = mant_big_r;
   assign bus.mant_small = mant_small_r;

endmodule
